// File: rtl/lcd_write_engine.sv
// HD44780 8-bit bus driver: runs power-on init, then writes one character per handshake,
// inserting DDRAM address commands when the cursor crosses line 1 -> 2 and line 2 -> 1.
module lcd_write_engine #(
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_WAIT_CYC  = 205000,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int E_PULSE_CYC    = 12
) (
  input  logic       clkFSM,
  input  logic       resetFSM_n,
  input  logic       writeStart,
  input  logic [7:0] data,
  output logic       initDone,
  output logic       writeDone,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  typedef enum logic [3:0] {
    PWR, ISSUE, SETUP, EHIGH, EWAIT, READY, WRAP, CHAR, DONE
  } state_t;

  // Terminal counts are stored as (cycles - 1) so a counter starting at 0 runs exactly N cycles.
  localparam logic [19:0] PWR_LAST   = 20'(POWERUP_CYC - 1);
  localparam logic [19:0] INIT_LAST  = 20'(INIT_WAIT_CYC - 1);
  localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_WAIT_CYC - 1);
  localparam logic [19:0] E_LAST     = 20'(E_PULSE_CYC - 1);

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h08;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      3'd7:    return 8'h0C;
      default: return 8'h38;
    endcase
  endfunction

  function automatic logic [19:0] init_wait(input logic [2:0] i);
    case (i)
      3'd0:    return INIT_LAST;
      3'd5:    return CLEAR_LAST;
      default: return CMD_LAST;
    endcase
  endfunction

  // state walks the bus transaction; owner records which job (ISSUE/WRAP/CHAR) the transaction serves.
  state_t      state, state_nxt;
  state_t      owner, owner_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [19:0] wait_q, wait_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [5:0]  col, col_nxt;
  logic [7:0]  char_q, char_nxt;
  logic        rs_q, rs_nxt;
  logic [7:0]  db_q, db_nxt;
  logic        init_q, init_nxt;
  logic        e_q, done_q;

  always_ff @(posedge clkFSM or negedge resetFSM_n) begin
    if (!resetFSM_n) begin
      state  <= PWR;
      owner  <= ISSUE;
      cnt    <= '0;
      wait_q <= '0;
      idx    <= '0;
      col    <= '0;
      char_q <= '0;
      rs_q   <= 1'b0;
      db_q   <= '0;
      init_q <= 1'b0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
      wait_q <= wait_nxt;
      idx    <= idx_nxt;
      col    <= col_nxt;
      char_q <= char_nxt;
      rs_q   <= rs_nxt;
      db_q   <= db_nxt;
      init_q <= init_nxt;
      e_q    <= (state_nxt == EHIGH);
      done_q <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    wait_nxt  = wait_q;
    idx_nxt   = idx;
    col_nxt   = col;
    char_nxt  = char_q;
    rs_nxt    = rs_q;
    db_nxt    = db_q;
    init_nxt  = init_q;

    case (state)
      PWR: begin
        if (cnt == PWR_LAST) begin
          state_nxt = SETUP;
          owner_nxt = ISSUE;
          cnt_nxt   = '0;
          idx_nxt   = 3'd0;
          rs_nxt    = 1'b0;
          db_nxt    = init_cmd(3'd0);
          wait_nxt  = init_wait(3'd0);
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end

      SETUP: begin
        state_nxt = EHIGH;
        cnt_nxt   = '0;
      end

      EHIGH: begin
        if (cnt == E_LAST) begin
          state_nxt = EWAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end

      EWAIT: begin
        if (cnt == wait_q) begin
          cnt_nxt = '0;
          case (owner)
            ISSUE: begin
              if (idx == 3'd7) begin
                init_nxt  = 1'b1;
                col_nxt   = '0;
                state_nxt = READY;
              end else begin
                idx_nxt   = idx + 3'd1;
                db_nxt    = init_cmd(idx + 3'd1);
                wait_nxt  = init_wait(idx + 3'd1);
                state_nxt = SETUP;
              end
            end
            // Address command done: the latched character follows immediately.
            WRAP: begin
              owner_nxt = CHAR;
              rs_nxt    = 1'b1;
              db_nxt    = char_q;
              wait_nxt  = CMD_LAST;
              state_nxt = SETUP;
            end
            CHAR: begin
              col_nxt   = col + 6'd1;
              state_nxt = DONE;
            end
            default: state_nxt = READY;
          endcase
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end

      READY: begin
        if (writeStart) begin
          char_nxt  = data;
          wait_nxt  = CMD_LAST;
          state_nxt = SETUP;
          if (col == 6'd16) begin
            owner_nxt = WRAP;
            rs_nxt    = 1'b0;
            db_nxt    = 8'hC0;
          end else if (col == 6'd32) begin
            owner_nxt = WRAP;
            rs_nxt    = 1'b0;
            db_nxt    = 8'h80;
            col_nxt   = '0;
          end else begin
            owner_nxt = CHAR;
            rs_nxt    = 1'b1;
            db_nxt    = data;
          end
        end
      end

      DONE: state_nxt = READY;

      default: state_nxt = PWR;
    endcase
  end

  assign initDone  = init_q;
  assign writeDone = done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;
  assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened timing (POWERUP=20, INIT=10, CMD=4, CLEAR=8, E=2).
module tb_lcd_write_engine;

  logic       clkFSM = 1'b0;
  logic       resetFSM_n = 1'b0;
  logic       writeStart = 1'b0;
  logic [7:0] data = 8'h00;
  logic       initDone, writeDone, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  always #5 clkFSM = ~clkFSM;

  lcd_write_engine #(
    .POWERUP_CYC(20), .INIT_WAIT_CYC(10), .CMD_WAIT_CYC(4),
    .CLEAR_WAIT_CYC(8), .E_PULSE_CYC(2)
  ) dut (
    .clkFSM(clkFSM), .resetFSM_n(resetFSM_n), .writeStart(writeStart), .data(data),
    .initDone(initDone), .writeDone(writeDone), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] pulse_q[$];
  int         len_q[$];
  int         cur_len = 0;
  logic       e_prev = 1'b0;
  int         wd_cnt = 0;
  logic [7:0] init_cmds[8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  // Mid-cycle bus monitor: one entry {rs,db} per E rising edge, one length per E pulse.
  always @(negedge clkFSM) begin
    if (writeDone) wd_cnt++;
    if (lcd_e && !e_prev) begin
      pulse_q.push_back({lcd_rs, lcd_db});
      cur_len = 1;
    end else if (lcd_e) begin
      cur_len++;
    end else if (e_prev) begin
      len_q.push_back(cur_len);
    end
    e_prev = lcd_e;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkFSM);
    #1;
  endtask

  function automatic logic [8:0] pulse_at(input int i);
    if (i < pulse_q.size()) return pulse_q[i];
    return 9'h1FF;
  endfunction

  function automatic int len_at(input int i);
    if (i < len_q.size()) return len_q[i];
    return -1;
  endfunction

  // Release reset and follow the init sequence; a stray writeStart is pulsed midway.
  task automatic run_init();
    int bp, bl, bw;
    bp = pulse_q.size();
    bl = len_q.size();
    bw = wd_cnt;
    resetFSM_n = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      tick();
      if (k == 30) writeStart = 1'b1;
      if (k == 31) writeStart = 1'b0;
    end
    check("init_early", initDone, 1'b0);
    tick();
    check("init_rise", initDone, 1'b1);
    check("init_npulse", pulse_q.size() - bp, 8);
    for (int i = 0; i < 8; i++) begin
      check("init_cmd", pulse_at(bp + i), {1'b0, init_cmds[i]});
      check("init_elen", len_at(bl + i), 2);
    end
    repeat (6) tick();
    check("idle_nopulse", pulse_q.size() - bp, 8);
    check("init_nodone", wd_cnt - bw, 0);
  endtask

  // One write handshake; wrap_cmd is the expected {rs,db} of a preceding address command, 0 if none.
  task automatic do_write(input logic [7:0] d, input logic [7:0] d_after, input bit poke,
                          input logic [8:0] wrap_cmd, input int exp_lat);
    int bp, bw, lat, exp_n;
    logic [15:0] emask;
    bp = pulse_q.size();
    bw = wd_cnt;
    lat = 999;
    emask = '0;
    exp_n = (wrap_cmd != 9'h0) ? 2 : 1;
    writeStart = 1'b1;
    data = d;
    tick();
    writeStart = 1'b0;
    data = d_after;
    for (int k = 1; k <= 40 && lat == 999; k++) begin
      if (poke && k == 3) writeStart = 1'b1;
      if (poke && k == 4) writeStart = 1'b0;
      tick();
      // value after edge N+k is what edge N+k+1 samples
      if (k < 15) emask[k+1] = lcd_e;
      if (writeDone) lat = k;
    end
    writeStart = 1'b0;
    check("wd_lat", lat, exp_lat);
    check("e_timing", emask, (exp_lat == 7) ? 16'h000C : 16'h060C);
    tick();
    check("wd_low", writeDone, 1'b0);
    check("wd_once", wd_cnt - bw, 1);
    check("npulse", pulse_q.size() - bp, exp_n);
    if (exp_n == 2) check("addr_cmd", pulse_at(bp), wrap_cmd);
    check("char", pulse_at(bp + exp_n - 1), {1'b1, d});
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outs", {initDone, writeDone, lcd_rs, lcd_rw, lcd_e, lcd_db}, 0);
    run_init();

    do_write(8'h49, 8'h49, 1'b0, 9'h0, 7);
    do_write(8'h42, 8'h4D, 1'b0, 9'h0, 7);
    do_write(8'h43, 8'h44, 1'b1, 9'h0, 7);
    for (int i = 4; i <= 33; i++) begin
      if (i == 17)      do_write(8'(8'h40 + i), 8'h00, 1'b0, 9'h0C0, 14);
      else if (i == 33) do_write(8'(8'h40 + i), 8'h00, 1'b0, 9'h080, 14);
      else              do_write(8'(8'h40 + i), 8'h00, 1'b0, 9'h0, 7);
    end

    // Reset while E is high, then full re-init.
    writeStart = 1'b1;
    data = 8'h5A;
    tick();
    writeStart = 1'b0;
    tick();
    check("pre_rst_e", {lcd_rw, lcd_e}, 2'b01);
    resetFSM_n = 1'b0;
    #1;
    check("rst_outs", {initDone, writeDone, lcd_rs, lcd_rw, lcd_e, lcd_db}, 0);
    repeat (3) tick();
    check("rst_hold", {initDone, writeDone, lcd_e}, 0);
    run_init();
    do_write(8'h52, 8'h00, 1'b0, 9'h0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Character-LCD bus driver (HD44780-compatible, 8-bit data mode) that sits directly downstream of the message-sequencing FSMs. It runs the LCD power-on initialisation, raises `initDone`, and then accepts one character per `writeStart`/`writeDone` handshake. Each character is driven onto the LCD pins with the required E-pulse timing. It tracks the cursor column and inserts DDRAM-address commands to move from line 1 to line 2, and to wrap back from line 2 to line 1.

## Interface
Parameters (cycle counts; defaults assume a 50 MHz clock):
- `POWERUP_CYC`, 750000, wait after reset before the first command (15 ms).
- `INIT_WAIT_CYC`, 205000, wait after the first function-set command (4.1 ms).
- `CMD_WAIT_CYC`, 2500, wait after every other command and after each character (50 µs).
- `CLEAR_WAIT_CYC`, 82000, wait after the clear command 0x01 (1.64 ms).
- `E_PULSE_CYC`, 12, number of cycles `lcd_e` is held high (240 ns).

Ports:
- `clkFSM`  in  1  system clock.
- `resetFSM_n`  in  1  reset; one clock; asynchronous, active-low.
- `writeStart`  in  1  single-cycle request to write `data`.
- `data`  in  8  ASCII character, sampled when `writeStart` is accepted.
- `initDone`  out  1  init complete; sticky until the next reset.
- `writeDone`  out  1  one-cycle pulse when the requested character is finished.
- `lcd_rs`  out  1  0 = command, 1 = character data.
- `lcd_rw`  out  1  tied to 0 (write only).
- `lcd_e`  out  1  enable strobe.
- `lcd_db`  out  8  LCD data bus.

## Operation
- Reset value of every output is 0; assertion of `resetFSM_n` = 0 forces this immediately, asynchronously.
- State machine states: PWR, ISSUE, SETUP, EHIGH, EWAIT, READY, WRAP, CHAR, DONE.
- **PWR**: count `POWERUP_CYC` cycles, then go to ISSUE with init index 0.
- **ISSUE**: init sequence, with `lcd_rs` = 0 for every command:
  - index 0: 0x38, followed by `INIT_WAIT_CYC`;
  - index 1–3: 0x38, 0x38, 0x38, each followed by `CMD_WAIT_CYC`;
  - index 4: 0x08, followed by `CMD_WAIT_CYC`;
  - index 5: 0x01, followed by `CLEAR_WAIT_CYC`;
  - index 6: 0x06, followed by `CMD_WAIT_CYC`;
  - index 7: 0x0C, followed by `CMD_WAIT_CYC`.
- **Bus transaction** (shared by commands and characters):
  - SETUP: 1 cycle; `lcd_rs` and `lcd_db` valid, `lcd_e` = 0.
  - EHIGH: `E_PULSE_CYC` cycles with `lcd_e` = 1.
  - EWAIT: the selected wait count with `lcd_e` = 0.
  - `lcd_rs` and `lcd_db` hold their values until the next SETUP.
- **End of init**: after index 7 completes, set `initDone` = 1, set column = 0, and enter READY.
- **READY**:
  - `writeStart` = 1 latches `data`.
  - If column = 16: go to WRAP and send command 0xC0.
  - If column = 32: go to WRAP, send command 0x80, and set column to 0.
  - Otherwise go straight to CHAR.
- **CHAR**: transaction with `lcd_rs` = 1 and the latched character, waiting `CMD_WAIT_CYC`; then column += 1, then DONE.
- **DONE**: `writeDone` = 1 for exactly one cycle, then return to READY.
- **`writeStart` outside READY** (during init or mid-write) is ignored; no queueing.
- **Data latch**: `data` is latched at acceptance. Later changes to `data` do not affect the write in progress.
- **Column counter**: 6 bits, range 0–32.
- **Wait counter**: 20 bits; sized for the largest parameter.

## Timing
- Transaction length = 1 + `E_PULSE_CYC` + wait cycles.
- **Normal write**: `writeStart` sampled at edge N.
  - SETUP occupies edge N+1.
  - `lcd_e` is high from edge N+2 through edge N+1+`E_PULSE_CYC`.
  - `writeDone` is high for the cycle following edge N+1+`E_PULSE_CYC`+`CMD_WAIT_CYC`.
- **Write with wrap**: adds one full command transaction ahead of the character transaction.
- **Earliest next request**: the cycle after the `writeDone` pulse, i.e. back-to-back with the requester's next `writeStart`.
- **Reset mid-transaction**:
  - `lcd_e` drops to 0 and `initDone`/`writeDone` clear immediately.
  - After release, the block restarts from PWR and runs the full init sequence.

## Test plan
All scenarios use parameters POWERUP=20, INIT_WAIT=10, CMD_WAIT=4, CLEAR_WAIT=8, E_PULSE=2.
- **Init**: release reset ->
  - `lcd_db` carries 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C on the 8 E-pulses, each pulse 2 cycles high, `lcd_rs` = 0;
  - `initDone` rises 86 cycles after release;
  - `writeDone` stays 0 throughout.
- **Single write**: one-cycle `writeStart` with `data` = 0x49 at edge N ->
  - one E-pulse with `lcd_rs` = 1 and `lcd_db` = 0x49, `lcd_e` high at edges N+2 and N+3;
  - `writeDone` pulses once after edge N+7.
- **Line wrap**: write 17 characters ->
  - the 17th write shows an E-pulse with `lcd_rs` = 0, `lcd_db` = 0xC0, then an E-pulse with `lcd_rs` = 1 and the character;
  - `writeDone` arrives 14 cycles after acceptance.
  - Continue to 33 characters -> the 33rd write is preceded by 0x80.
- **Ignored requests**:
  - `writeStart` pulsed during init -> no extra E-pulse and no `writeDone`.
  - `writeStart` pulsed during an active write -> exactly one `writeDone` results.
- **Data latch**: change `data` from 0x42 to 0x4D one cycle after acceptance -> the LCD receives 0x42.
- **Reset mid-operation**: assert `resetFSM_n` = 0 while `lcd_e` = 1 ->
  - all outputs are 0 within the same cycle;
  - after release, the full init sequence repeats and `initDone` rises after 86 cycles.
